// File: rtl/date_pkg.sv
// Shared definitions for the calendar date block: field widths, month codes
// and the normal/set mode encoding.
package date_pkg;

    localparam int YEAR_W  = 7;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;

    localparam logic [YEAR_W-1:0] YEAR_MAX = 7'd99;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    typedef enum logic {DATE_NORMAL, DATE_SET} date_mode_e;

endpackage

// File: rtl/date_adjust_if.sv
// Control/date bus between the control FSMs (master) and date_adjust (slave).
// set_date_dec exists only when DATE_ADJUST_DEC_EN is defined.
interface date_adjust_if;
    import date_pkg::*;

    logic               set_date_en;
    logic               set_year_en;
    logic               set_month_en;
    logic               set_day_en;
    logic               set_date_inc;
`ifdef DATE_ADJUST_DEC_EN
    logic               set_date_dec;
`endif
    logic               day_tick;
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
    logic [DAY_W-1:0]   max_day;
    logic               year_wrap;

    modport master (
`ifdef DATE_ADJUST_DEC_EN
        output set_date_dec,
`endif
        output set_date_en, set_year_en, set_month_en, set_day_en,
        output set_date_inc, day_tick,
        input  year, month, day, max_day, year_wrap
    );

    modport slave (
`ifdef DATE_ADJUST_DEC_EN
        input  set_date_dec,
`endif
        input  set_date_en, set_year_en, set_month_en, set_day_en,
        input  set_date_inc, day_tick,
        output year, month, day, max_day, year_wrap
    );

endinterface

// File: rtl/days_in_month.sv
// Combinational month length for a given month/year offset. Leap rule is the
// plain divisible-by-4 test, which is exact across 2000..2099.
module days_in_month
    import date_pkg::*;
#(
    parameter int YEAR_BASE = 2000
) (
    input  logic [MONTH_W-1:0] month_i,
    input  logic [YEAR_W-1:0]  year_i,
    output logic [DAY_W-1:0]   max_day_o
);

    logic leap;
    assign leap = ((YEAR_BASE + int'(year_i)) % 4) == 0;

    // Month length lookup; out-of-range months fall back to 31
    always_comb begin
        case (month_i)
            APR, JUN, SEP, NOV: max_day_o = 5'd30;
            FEB:                max_day_o = leap ? 5'd29 : 5'd28;
            default:            max_day_o = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_adjust.sv
// Calendar date registers. Normal mode advances on day_tick; set mode steps the
// single selected field. Any month/year change clamps day to the new month
// length in the same cycle. Optional macro DATE_ADJUST_DEC_EN adds decrement.
module date_adjust
    import date_pkg::*;
#(
    parameter int YEAR_BASE = 2000,
    parameter int RST_YEAR  = 0,
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    date_adjust_if.slave  bus
);

    logic [YEAR_W-1:0]  year_q,  year_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [DAY_W-1:0]   day_q,   day_d, day_n;
    logic               wrap_q,  wrap_d;
    logic [DAY_W-1:0]   max_cur, max_new;
    date_mode_e         mode;
    logic               one_hot, inc_s, dec_s;

    assign mode    = bus.set_date_en ? DATE_SET : DATE_NORMAL;
    assign one_hot = ({bus.set_year_en, bus.set_month_en, bus.set_day_en} == 3'b100) ||
                     ({bus.set_year_en, bus.set_month_en, bus.set_day_en} == 3'b010) ||
                     ({bus.set_year_en, bus.set_month_en, bus.set_day_en} == 3'b001);

`ifdef DATE_ADJUST_DEC_EN
    // Simultaneous inc and dec cancel out
    assign inc_s = bus.set_date_inc & ~bus.set_date_dec;
    assign dec_s = bus.set_date_dec & ~bus.set_date_inc;
`else
    assign inc_s = bus.set_date_inc;
    assign dec_s = 1'b0;
`endif

    // Length of the month currently held; also the max_day output
    days_in_month #(.YEAR_BASE(YEAR_BASE)) u_dim_cur (
        .month_i   (month_q),
        .year_i    (year_q),
        .max_day_o (max_cur)
    );

    // Length of the month about to be loaded, used for the day clamp
    days_in_month #(.YEAR_BASE(YEAR_BASE)) u_dim_new (
        .month_i   (month_d),
        .year_i    (year_d),
        .max_day_o (max_new)
    );

    // Candidate next date before clamping
    always_comb begin
        year_d  = year_q;
        month_d = month_q;
        day_n   = day_q;
        wrap_d  = 1'b0;
        case (mode)
            DATE_NORMAL: begin
                if (bus.day_tick) begin
                    if (day_q < max_cur) begin
                        day_n = day_q + 5'd1;
                    end else begin
                        day_n = 5'd1;
                        if (month_q == DEC) begin
                            month_d = JAN;
                            if (year_q == YEAR_MAX) begin
                                year_d = '0;
                                wrap_d = 1'b1;
                            end else begin
                                year_d = year_q + 7'd1;
                            end
                        end else begin
                            month_d = month_q + 4'd1;
                        end
                    end
                end
            end
            DATE_SET: begin
                if (one_hot && (inc_s || dec_s)) begin
                    if (bus.set_day_en) begin
                        if (inc_s) day_n = (day_q >= max_cur) ? 5'd1 : day_q + 5'd1;
                        else       day_n = (day_q <= 5'd1) ? max_cur : day_q - 5'd1;
                    end
                    if (bus.set_month_en) begin
                        if (inc_s) month_d = (month_q >= DEC) ? JAN : month_q + 4'd1;
                        else       month_d = (month_q <= JAN) ? DEC : month_q - 4'd1;
                    end
                    if (bus.set_year_en) begin
                        if (inc_s) year_d = (year_q >= YEAR_MAX) ? 7'd0 : year_q + 7'd1;
                        else       year_d = (year_q == 7'd0) ? YEAR_MAX : year_q - 7'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Clamp day into the new month so e.g. Jan 31 -> Feb lands on Feb 28/29
    assign day_d = (day_n > max_new) ? max_new : day_n;

    // Date and year-wrap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year_q  <= YEAR_W'(RST_YEAR);
            month_q <= MONTH_W'(RST_MONTH);
            day_q   <= DAY_W'(RST_DAY);
            wrap_q  <= 1'b0;
        end else begin
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.year      = year_q;
    assign bus.month     = month_q;
    assign bus.day       = day_q;
    assign bus.max_day   = max_cur;
    assign bus.year_wrap = wrap_q;

endmodule
